// File: rtl/serial_add_pkg.sv
// Shared types and helpers for the bit-serial adder sequencer.
package serial_add_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_e;

    // Bit counter width; never below 1 so WIDTH=1 still has a counter flop.
    function automatic int cnt_width(input int width);
        if ($clog2(width) < 1) begin
            return 1;
        end
        return $clog2(width);
    endfunction

endpackage

// File: rtl/serial_add_ctrl_fa.sv
// Single-bit full adder cell reused once per bit step by serial_add_ctrl.
module FA (
    input  logic a,
    input  logic b,
    input  logic Cin,
    output logic s,
    output logic Cout
);

    assign s    = a ^ b ^ Cin;
    assign Cout = (a & b) | (Cin & (a ^ b));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one FA cell, LSB first, registered carry between steps.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] r_sh_q, r_sh_d;
    logic             carry_q, carry_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             fa_s;
    logic             fa_cout;
    logic [WIDTH-1:0] r_shifted;

    FA u_fa (
        .a    (a_sh_q[0]),
        .b    (b_sh_q[0]),
        .Cin  (carry_q),
        .s    (fa_s),
        .Cout (fa_cout)
    );

    // Result register fills from the MSB side so bit 0 ends up at the LSB.
    generate
        if (WIDTH == 1) begin : g_r_w1
            assign r_shifted = fa_s;
        end else begin : g_r_wn
            assign r_shifted = {fa_s, r_sh_q[WIDTH-1:1]};
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        r_sh_d  = r_sh_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    a_sh_d  = a;
                    b_sh_d  = b;
                    carry_d = cin;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                a_sh_d  = a_sh_q >> 1;
                b_sh_d  = b_sh_q >> 1;
                r_sh_d  = r_shifted;
                carry_d = fa_cout;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_BIT) begin
                    state_d = DONE;
                    sum_d   = r_shifted;
                    cout_d  = fa_cout;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            r_sh_q  <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            r_sh_q  <= r_sh_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl at WIDTH=8 and WIDTH=1.
module tb_serial_add_ctrl;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       busy;
    logic       done;
    logic [7:0] sum;
    logic       cout;

    logic       start_w1;
    logic [0:0] a_w1;
    logic [0:0] b_w1;
    logic       cin_w1;
    logic       busy_w1;
    logic       done_w1;
    logic [0:0] sum_w1;
    logic       cout_w1;

    int passed = 0;
    int total  = 0;
    int failed = 0;

    serial_add_ctrl #(.WIDTH(8)) u_dut8 (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    serial_add_ctrl #(.WIDTH(1)) u_dut1 (
        .clk   (clk),
        .rst   (rst),
        .start (start_w1),
        .a     (a_w1),
        .b     (b_w1),
        .cin   (cin_w1),
        .busy  (busy_w1),
        .done  (done_w1),
        .sum   (sum_w1),
        .cout  (cout_w1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One-cycle start, then watch 14 cycles measured from the accept edge.
    task automatic do_add(input logic [7:0] av, input logic [7:0] bv, input logic cv,
                          output int lat, output int bcnt, output int dcnt);
        a = av; b = bv; cin = cv; start = 1'b1;
        step();
        start = 1'b0;
        lat = -1; bcnt = 0; dcnt = 0;
        for (int k = 0; k < 14; k++) begin
            if (busy) bcnt++;
            if (done) begin
                dcnt++;
                if (lat < 0) lat = k;
            end
            step();
        end
    endtask

    initial begin
        int lat, bcnt, dcnt;
        int dts[$];

        rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        start_w1 = 1'b0; a_w1 = '0; b_w1 = '0; cin_w1 = 1'b0;
        @(negedge clk);
        step();
        step();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_sum", sum, 0);
        chk("rst_cout", cout, 0);
        chk("rst_busy_w1", busy_w1, 0);
        chk("rst_sum_w1", sum_w1, 0);
        rst = 1'b0;
        step();
        chk("idle_busy", busy, 0);
        $display("reset: busy=%0b done=%0b sum=%h cout=%0b", busy, done, sum, cout);

        do_add(8'h3C, 8'h05, 1'b0, lat, bcnt, dcnt);
        chk("t1_latency", lat, 8);
        chk("t1_busy_cycles", bcnt, 9);
        chk("t1_done_count", dcnt, 1);
        chk("t1_sum", sum, 8'h41);
        chk("t1_cout", cout, 0);
        $display("3C+05+0: lat=%0d busy=%0d sum=%h cout=%0b", lat, bcnt, sum, cout);

        do_add(8'hFF, 8'h01, 1'b0, lat, bcnt, dcnt);
        chk("t2a_sum", sum, 8'h00);
        chk("t2a_cout", cout, 1);
        $display("FF+01+0: sum=%h cout=%0b", sum, cout);
        do_add(8'hFF, 8'h00, 1'b1, lat, bcnt, dcnt);
        chk("t2b_sum", sum, 8'h00);
        chk("t2b_cout", cout, 1);
        chk("t2b_latency", lat, 8);
        $display("FF+00+1: sum=%h cout=%0b", sum, cout);

        a = 8'h01; b = 8'h01; cin = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        a = 8'h10; b = 8'h20; start = 1'b1;
        step();
        start = 1'b0; a = '0; b = '0;
        chk("t3_sum_hold", sum, 8'h00);
        chk("t3_cout_hold", cout, 1);
        lat = -1; dcnt = 0;
        for (int k = 3; k < 17; k++) begin
            if (done) begin
                dcnt++;
                lat = k;
            end
            step();
        end
        chk("t3_latency", lat, 8);
        chk("t3_done_count", dcnt, 1);
        chk("t3_sum", sum, 8'h02);
        chk("t3_cout", cout, 0);
        $display("01+01 with ignored 10+20: lat=%0d dones=%0d sum=%h", lat, dcnt, sum);

        a = 8'h7F; b = 8'h01; cin = 1'b0; start = 1'b1;
        for (int c = 0; c < 40; c++) begin
            step();
            if (done) begin
                dts.push_back(c);
                chk("t4_sum", sum, 8'h80);
                chk("t4_cout", cout, 0);
            end
        end
        start = 1'b0;
        chk("t4_done_count", dts.size(), 4);
        for (int i = 1; i < dts.size(); i++) begin
            chk("t4_period", dts[i] - dts[i-1], 10);
        end
        $display("7F+01 held start: dones=%0d first=%0d", dts.size(), (dts.size() > 0) ? dts[0] : -1);
        for (int i = 0; i < 12; i++) step();

        a = 8'hAA; b = 8'h55; cin = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t5_busy", busy, 0);
        chk("t5_done", done, 0);
        chk("t5_sum", sum, 0);
        chk("t5_cout", cout, 0);
        dcnt = 0; bcnt = 0;
        for (int k = 0; k < 12; k++) begin
            if (done) dcnt++;
            if (busy) bcnt++;
            step();
        end
        chk("t5_no_done", dcnt, 0);
        chk("t5_stays_idle", bcnt, 0);
        do_add(8'h01, 8'h02, 1'b0, lat, bcnt, dcnt);
        chk("t5_post_latency", lat, 8);
        chk("t5_post_sum", sum, 8'h03);
        chk("t5_post_cout", cout, 0);
        $display("AA+55 aborted, then 01+02: sum=%h cout=%0b", sum, cout);

        a_w1 = 1'b1; b_w1 = 1'b1; cin_w1 = 1'b1; start_w1 = 1'b1;
        step();
        start_w1 = 1'b0;
        chk("w1_busy", busy_w1, 1);
        chk("w1_done_early", done_w1, 0);
        step();
        chk("w1_done", done_w1, 1);
        chk("w1_sum", sum_w1, 1);
        chk("w1_cout", cout_w1, 1);
        step();
        chk("w1_done_pulse", done_w1, 0);
        chk("w1_busy_off", busy_w1, 0);
        $display("W1 1+1+1: sum=%0b cout=%0b", sum_w1, cout_w1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
